// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory/MMIO responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_e;

  // Byte offsets of the MMIO registers from MMIO_BASE
  localparam logic [4:0] OFF_TOHOST    = 5'h00;
  localparam logic [4:0] OFF_CYCLE_LO  = 5'h04;
  localparam logic [4:0] OFF_CYCLE_HI  = 5'h08;
  localparam logic [4:0] OFF_STORE_CNT = 5'h0C;
  localparam logic [4:0] OFF_STATUS    = 5'h10;

  localparam int STATUS_DONE_BIT = 0;
  localparam int STATUS_ERR_BIT  = 1;

endpackage

// File: rtl/dmem_store_align.sv
// Store lane steering: turns size/address/data into byte enables, replicated
// lane data and an alignment-violation flag.
module dmem_store_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  adr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  byte_en,
  output logic [31:0] lane_data,
  output logic        misaligned
);

  always_comb begin
    byte_en    = 4'b0000;
    lane_data  = wdata;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        byte_en   = 4'b0001 << adr_lo;
        lane_data = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        byte_en    = adr_lo[1] ? 4'b1100 : 4'b0011;
        lane_data  = {2{wdata[15:0]}};
        misaligned = adr_lo[0];
      end
      SZ_WORD: begin
        byte_en    = 4'b1111;
        misaligned = |adr_lo;
      end
      // Reserved size is rejected the same way as a misaligned store
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_memory_mmio.sv
// Data-memory responder: word RAM plus a small MMIO block (tohost, cycle
// counter, store counter, status). Loads are combinational, stores on the edge.
module data_memory_mmio
  import dmem_pkg::*;
#(
  parameter int          MEM_WORDS = 64,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Done,
  output logic [31:0] DoneValue,
  output logic        Err
);

  localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);

  logic [31:0]      mem [MEM_WORDS];
  logic [63:0]      cycle_reg;
  logic [31:0]      store_cnt_reg;
  logic [31:0]      done_value_reg;
  logic             done_reg;
  logic             err_reg;

  logic [3:0]       byte_en;
  logic [31:0]      lane_data;
  logic             misaligned;
  logic             ram_hit;
  logic             mmio_hit;
  logic             illegal;
  logic             ram_we;
  logic             mmio_we;
  logic [4:0]       off;
  logic [IDX_W-1:0] word_idx;

  dmem_store_align u_align (
    .size       (MemSize),
    .adr_lo     (DataAdr[1:0]),
    .wdata      (WriteData),
    .byte_en    (byte_en),
    .lane_data  (lane_data),
    .misaligned (misaligned)
  );

  // MMIO registers are decoded on the word address so sub-word loads see the whole register
  assign off      = {DataAdr[4:2], 2'b00};
  assign word_idx = DataAdr[IDX_W+1:2];
  assign ram_hit  = DataAdr < RAM_BYTES;
  assign mmio_hit = (DataAdr[31:5] == MMIO_BASE[31:5]) &&
                    (off inside {OFF_TOHOST, OFF_CYCLE_LO, OFF_CYCLE_HI, OFF_STORE_CNT, OFF_STATUS});
  assign illegal  = misaligned || !(ram_hit || mmio_hit) || (mmio_hit && MemSize != SZ_WORD);
  assign ram_we   = MemWrite && ram_hit && !illegal;
  assign mmio_we  = MemWrite && mmio_hit && !illegal;

  // RAM is not reset; reset only blocks the write
  always_ff @(posedge clk) begin
    if (ram_we && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][b*8 +: 8] <= lane_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_reg      <= '0;
      store_cnt_reg  <= '0;
      done_value_reg <= '0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      cycle_reg <= cycle_reg + 64'd1;

      if (MemWrite && illegal)
        err_reg <= 1'b1;
      else if (mmio_we && off == OFF_STATUS && WriteData[STATUS_ERR_BIT])
        err_reg <= 1'b0;

      if (mmio_we && off == OFF_TOHOST && !done_reg) begin
        done_reg       <= 1'b1;
        done_value_reg <= WriteData;
      end

      if (mmio_we && off == OFF_STORE_CNT)
        store_cnt_reg <= WriteData;
      else if (ram_we && store_cnt_reg != 32'hFFFF_FFFF)
        store_cnt_reg <= store_cnt_reg + 32'd1;
    end
  end

  always_comb begin
    ReadData = '0;
    if (ram_hit) begin
      ReadData = mem[word_idx];
    end else if (mmio_hit) begin
      case (off)
        OFF_TOHOST:    ReadData = done_value_reg;
        OFF_CYCLE_LO:  ReadData = cycle_reg[31:0];
        OFF_CYCLE_HI:  ReadData = cycle_reg[63:32];
        OFF_STORE_CNT: ReadData = store_cnt_reg;
        OFF_STATUS: begin
          ReadData[STATUS_DONE_BIT] = done_reg;
          ReadData[STATUS_ERR_BIT]  = err_reg;
        end
        default:       ReadData = '0;
      endcase
    end
  end

  assign Done      = done_reg;
  assign DoneValue = done_value_reg;
  assign Err       = err_reg;

endmodule

// File: tb/tb_data_memory_mmio.sv
// Bench for data_memory_mmio: directed vector table, randomized traffic against
// a byte-array reference model, and hand-written reset / cycle-counter sequences.
module tb_data_memory_mmio;

  localparam logic [31:0] BASE     = 32'hFFFF_FF00;
  localparam logic [31:0] A_TOHOST = BASE;
  localparam logic [31:0] A_CLO    = BASE + 32'h4;
  localparam logic [31:0] A_CHI    = BASE + 32'h8;
  localparam logic [31:0] A_CNT    = BASE + 32'hC;
  localparam logic [31:0] A_STAT   = BASE + 32'h10;
  localparam logic [1:0]  B = 2'd0, H = 2'd1, W = 2'd2, R = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [1:0]  MemSize = 2'd0;
  logic [31:0] DataAdr = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic [31:0] ReadData;
  logic        Done;
  logic [31:0] DoneValue;
  logic        Err;

  data_memory_mmio dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .MemSize   (MemSize),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Done      (Done),
    .DoneValue (DoneValue),
    .Err       (Err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [7:0]  m_mem [256];
  logic [31:0] m_cnt, m_dv;
  logic        m_done, m_err;
  logic [63:0] tb_cycles = 64'd0;

  // Rising edges seen since the last edge at which reset was high
  always @(posedge clk) begin
    if (reset) tb_cycles <= 64'd0;
    else       tb_cycles <= tb_cycles + 64'd1;
  end

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic we, input logic [1:0] sz, input logic [31:0] adr,
                     input logic [31:0] wd, input logic c, input logic [31:0] e,
                     input logic ee, input logic ed);
    vec_t v;
    v.we = we; v.sz = sz; v.adr = adr; v.wd = wd;
    v.chk_rd = c; v.exp_rd = e; v.exp_err = ee; v.exp_done = ed;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 32'd0; m_dv = 32'd0; m_done = 1'b0; m_err = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] adr);
    logic [31:0] a;
    a = adr & 32'hFFFF_FFFC;
    if (a < 32'd256) return {m_mem[a+3], m_mem[a+2], m_mem[a+1], m_mem[a]};
    case (a)
      A_TOHOST: return m_dv;
      A_CLO:    return tb_cycles[31:0];
      A_CHI:    return tb_cycles[63:32];
      A_CNT:    return m_cnt;
      A_STAT:   return {30'd0, m_err, m_done};
      default:  return 32'd0;
    endcase
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] adr, input logic [31:0] wd);
    int n;
    n = (sz == B) ? 1 : (sz == H) ? 2 : (sz == W) ? 4 : 0;
    if (n == 0 || (int'(adr[1:0]) % n) != 0) begin
      m_err = 1'b1;
    end else if (adr < 32'd256) begin
      for (int k = 0; k < n; k++) m_mem[adr + k] = wd[8*k +: 8];
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end else if (adr >= A_TOHOST && adr <= A_STAT + 32'd3) begin
      if (n != 4) m_err = 1'b1;
      else begin
        case (adr)
          A_TOHOST: if (!m_done) begin m_done = 1'b1; m_dv = wd; end
          A_CNT:    m_cnt = wd;
          A_STAT:   if (wd[1]) m_err = 1'b0;
          default:  ;
        endcase
      end
    end else begin
      m_err = 1'b1;
    end
  endtask

  // One bus cycle: drive after the falling edge, sample the combinational read
  // before the rising edge, then apply the store to the model on the edge.
  task automatic op(input logic we, input logic [1:0] sz, input logic [31:0] adr,
                    input logic [31:0] wd, output logic [31:0] rd, output logic [31:0] exp_rd);
    @(negedge clk);
    MemWrite = we; MemSize = sz; DataAdr = adr; WriteData = wd;
    #1;
    rd = ReadData;
    exp_rd = model_read(adr);
    @(posedge clk);
    if (we && !reset) model_store(sz, adr, wd);
    #1;
    MemWrite = 1'b0;
    $display("op we=%0d sz=%0d adr=%08h wd=%08h rd=%08h err=%0d done=%0d",
             we, sz, adr, wd, rd, Err, Done);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, erd, adr;
    int cls;

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    chk("reset_done", {31'd0, Done}, 32'd0);
    chk("reset_err", {31'd0, Err}, 32'd0);
    chk("reset_donevalue", DoneValue, 32'd0);

    // Give every RAM word a known value
    for (int w = 0; w < 64; w++) op(1'b1, W, 32'(w * 4), $urandom, rd, erd);
    op(1'b0, W, A_CNT, 32'd0, rd, erd);
    chk("fill_store_cnt", rd, 32'd64);

    // Fresh counters for the directed table; RAM keeps its contents
    @(negedge clk) reset = 1'b1;
    model_reset();
    @(negedge clk) reset = 1'b0;
    op(1'b0, W, A_CNT, 32'd0, rd, erd);
    chk("reset_store_cnt", rd, 32'd0);

    add(1, W, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
    add(0, W, 32'h10, 0, 1, 32'hDEADBEEF, 0, 0);
    add(0, W, A_CNT, 0, 1, 32'd1, 0, 0);
    add(1, W, 32'h10, 32'h11223344, 0, 0, 0, 0);
    add(1, B, 32'h11, 32'hAA, 0, 0, 0, 0);
    add(0, W, 32'h10, 0, 1, 32'h1122AA44, 0, 0);
    add(1, H, 32'h12, 32'h5566, 0, 0, 0, 0);
    add(0, W, 32'h10, 0, 1, 32'h5566AA44, 0, 0);
    add(1, H, 32'h13, 32'hFFFF, 0, 0, 1, 0);
    add(1, W, 32'h16, 32'hFFFFFFFF, 0, 0, 1, 0);
    add(0, W, 32'h10, 0, 1, 32'h5566AA44, 1, 0);
    add(0, W, A_CNT, 0, 1, 32'd4, 1, 0);
    add(0, W, A_STAT, 0, 1, 32'd2, 1, 0);
    add(1, W, A_STAT, 32'd2, 0, 0, 0, 0);
    add(0, W, A_STAT, 0, 1, 32'd0, 0, 0);
    add(1, W, 32'h4000, 0, 0, 0, 1, 0);
    add(0, W, 32'h4000, 0, 1, 32'd0, 1, 0);
    add(1, W, A_STAT, 32'd2, 0, 0, 0, 0);
    add(1, W, A_TOHOST, 32'd1, 0, 0, 0, 1);
    add(1, W, A_TOHOST, 32'd7, 0, 0, 0, 1);
    add(0, W, A_TOHOST, 0, 1, 32'd1, 0, 1);
    add(0, W, A_STAT, 0, 1, 32'd1, 0, 1);
    add(1, B, A_STAT, 32'd2, 0, 0, 1, 1);
    add(1, W, A_STAT, 32'd2, 0, 0, 0, 1);
    add(1, W, A_STAT + 1, 32'd2, 0, 0, 1, 1);
    add(1, W, A_STAT, 32'd2, 0, 0, 0, 1);
    add(1, R, 32'h20, 0, 0, 0, 1, 1);
    add(1, W, A_STAT, 32'd2, 0, 0, 0, 1);
    add(1, W, A_CLO, 0, 0, 0, 0, 1);
    add(1, W, BASE + 32'h14, 0, 0, 0, 1, 1);
    add(1, W, A_STAT, 32'd2, 0, 0, 0, 1);
    add(1, W, A_CNT, 32'hFFFFFFFE, 0, 0, 0, 1);
    add(1, B, 32'h0, 32'd5, 0, 0, 0, 1);
    add(1, H, 32'h2, 32'd6, 0, 0, 0, 1);
    add(0, W, A_CNT, 0, 1, 32'hFFFFFFFF, 0, 1);
    add(1, W, 32'hFC, 32'h12345678, 0, 0, 0, 1);
    add(0, W, 32'hFC, 0, 1, 32'h12345678, 0, 1);
    add(1, B, 32'h100, 32'd1, 0, 0, 1, 1);
    add(0, W, 32'h100, 0, 1, 32'd0, 1, 1);
    add(0, W, 32'hFFFFFE10, 0, 1, 32'd0, 1, 1);
    add(0, W, A_STAT + 3, 0, 1, 32'd3, 1, 1);

    foreach (vecs[i]) begin
      op(vecs[i].we, vecs[i].sz, vecs[i].adr, vecs[i].wd, rd, erd);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'd0, Err}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_done", i), {31'd0, Done}, {31'd0, vecs[i].exp_done});
    end
    chk("tohost_first_wins", DoneValue, 32'd1);

    for (int t = 0; t < 400; t++) begin
      cls = $urandom_range(0, 9);
      if (cls <= 5)      adr = 32'($urandom_range(0, 255));
      else if (cls <= 7) adr = BASE + 32'($urandom_range(0, 31));
      else if (cls == 8) adr = 32'($urandom_range(256, 271));
      else               adr = $urandom;
      op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), adr, $urandom, rd, erd);
      chk("rnd_rd", rd, erd);
      chk("rnd_err", {31'd0, Err}, {31'd0, m_err});
      chk("rnd_done", {31'd0, Done}, {31'd0, m_done});
      chk("rnd_donevalue", DoneValue, m_dv);
    end

    // Asynchronous reset mid-run with Done, Err and the counter all non-zero
    op(1'b1, B, 32'h100, 32'd0, rd, erd);
    op(1'b1, W, A_TOHOST, 32'h55, rd, erd);
    chk("pre_rst_err", {31'd0, Err}, 32'd1);
    chk("pre_rst_done", {31'd0, Done}, 32'd1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    model_reset();
    DataAdr = A_CLO;
    #1;
    chk("async_rst_cycle", ReadData, 32'd0);
    chk("async_rst_done", {31'd0, Done}, 32'd0);
    chk("async_rst_err", {31'd0, Err}, 32'd0);
    chk("async_rst_donevalue", DoneValue, 32'd0);

    // A store presented while reset is held must not reach the RAM
    @(negedge clk);
    MemWrite = 1'b1; MemSize = W; DataAdr = 32'h20; WriteData = 32'hDEAD0000;
    @(posedge clk);
    #1 MemWrite = 1'b0;

    // Released after a falling edge; sampled 1 unit after the 10th rising edge => exactly 10
    @(negedge clk);
    reset = 1'b0;
    DataAdr = A_CLO;
    repeat (10) @(posedge clk);
    #1;
    chk("cycle_lo_10", ReadData, 32'd10);
    DataAdr = A_CHI;
    #1;
    chk("cycle_hi_0", ReadData, 32'd0);

    op(1'b0, W, 32'h20, 32'd0, rd, erd);
    chk("rst_store_ignored", rd, erd);
    op(1'b0, W, A_CNT, 32'd0, rd, erd);
    chk("post_rst_store_cnt", rd, 32'd0);
    op(1'b0, W, A_CLO, 32'd0, rd, erd);
    chk("post_rst_cycle_model", rd, erd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_memory_mmio.md
Name: data_memory_mmio

Overview:
- Responder end of the single-cycle core's data-memory interface.
- Decodes DataAdr into a word-organised RAM region and a small MMIO register block (tohost/done, cycle counter, store counter, status).
- Accepts stores with byte/half/word size on the clock edge and returns ReadData combinationally, so the single-cycle load path sees data in the same cycle.
- Sits beside instruction memory at top level and replaces the plain data memory. Testbenches watch Done/DoneValue to end simulation.

Parameters:
- MEM_WORDS, 64, number of 32-bit RAM words; RAM occupies byte addresses 0 .. MEM_WORDS*4-1.
- MMIO_BASE, 32'hFFFF_FF00, base of the MMIO block. Registers sit at +0x00 TOHOST, +0x04 CYCLE_LO, +0x08 CYCLE_HI, +0x0C STORE_CNT, +0x10 STATUS.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- MemWrite  input  1  store strobe from core, sampled at the rising edge of clk.
- MemSize  input  2  store size: 00 byte, 01 half, 10 word, 11 reserved.
- DataAdr  input  32  byte address from core.
- WriteData  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- ReadData  output  32  aligned word at DataAdr[31:2]; combinational.
- Done  output  1  registered; set by the first TOHOST write.
- DoneValue  output  32  registered; data of the first TOHOST write.
- Err  output  1  registered sticky error flag.

Behaviour:
- Reset: Done=0, DoneValue=0, Err=0, cycle counter=0, STORE_CNT=0. RAM contents are not reset.
- While reset is asserted, writes are ignored. Reset mid-store aborts that store.
- Decode is combinational:
  - RAM hit when DataAdr < MEM_WORDS*4.
  - MMIO hit when DataAdr[31:5] == MMIO_BASE[31:5] and the offset is one of the five listed.
  - Anything else is unmapped.
- Reads are combinational, zero latency:
  - RAM hit: full aligned word.
  - MMIO hit: register value.
  - Unmapped or unused MMIO offset: 32'h0.
  - The core does byte/half extraction. Reads never affect state.
- RAM store, applied at the clock edge when MemWrite=1:
  - Byte: lane DataAdr[1:0] gets WriteData[7:0].
  - Half: lanes {DataAdr[1],0} and {DataAdr[1],1} get WriteData[15:0]; legal only when DataAdr[0]=0.
  - Word: all lanes get WriteData; legal only when DataAdr[1:0]=00.
- Illegal stores: misaligned store, MemSize=11, store to unmapped address, or non-word MMIO store.
  - No state changes.
  - Err is set at the next edge.
- STORE_CNT increments on each accepted RAM store and saturates at 32'hFFFF_FFFF.
- Cycle counter:
  - 64-bit, increments every clock while not in reset, wraps to 0 after all-ones.
  - CYCLE_LO/CYCLE_HI are read-only; word writes to them are accepted and ignored (no Err).
- TOHOST:
  - A word write while Done=0 sets Done=1 and DoneValue=WriteData at that edge.
  - A write while Done=1 is ignored; first value wins.
  - Reads return DoneValue.
- STATUS:
  - Reads {30'b0, Err, Done}.
  - A word write with bit1=1 clears Err (W1C). Bit0 is read-only.
  - If a clear and a new illegal store occur in the same cycle, set wins (Err=1). With a single strobe this happens only for a misaligned STATUS write, which is itself illegal and therefore sets Err.
- STORE_CNT is writable only by word store; the written value replaces it. If a write and an increment coincide (impossible, disjoint addresses), the write wins.
- No backpressure, no wait states; every access completes in its cycle.

Decomposition:
- Package dmem_pkg:
  - mem_size_e enum (SZ_BYTE, SZ_HALF, SZ_WORD).
  - MMIO offset localparams (OFF_TOHOST, OFF_CYCLE_LO, OFF_CYCLE_HI, OFF_STORE_CNT, OFF_STATUS).
  - STATUS bit indices.
- Natural sub-module: dmem_store_align. Combinational: maps MemSize, DataAdr[1:0] and WriteData to a 4-bit byte enable, lane-shifted write data and a misaligned flag. The top holds the RAM and MMIO state.

Test Plan:
- Word store 32'hDEADBEEF to 0x10, then read 0x10 → ReadData=32'hDEADBEEF in the same cycle; STORE_CNT=1.
- Byte store 8'hAA to 0x11 over 32'h11223344 → reading 0x10 returns 32'h1122AA44. Half store 16'h5566 to 0x12 → 32'h5566AA44.
- Half store to 0x13 and word store to 0x16 → RAM unchanged, Err=1 after the edge, STORE_CNT unchanged. STATUS write 32'h2 → Err=0. STATUS read → 32'h0 (Done=0).
- Store to 0x0000_4000 (unmapped) → Err=1. Read of 0x0000_4000 → 32'h0.
- TOHOST write 32'h1, then TOHOST write 32'h7 → Done=1, DoneValue=32'h1 held. STATUS read → bit0=1.
- Release reset, run 10 cycles, read CYCLE_LO → 10 (±1 per the sampling edge, documented in the bench). Assert reset mid-run → counter, Done, Err return to 0 immediately, without waiting for a clock edge.
